// File: rtl/parallel_adder_pkg.sv
// ---------------------------------------------------------------------------
// parallel_adder_pkg
//   Shared constants and types for the registered ripple-carry adder.
//   PA_DEFAULT_WIDTH : default operand/sum width of parallel_adder_4bit
//   pa_word_t        : operand word at the default width
// ---------------------------------------------------------------------------
package parallel_adder_pkg;

   localparam int PA_DEFAULT_WIDTH = 4;

   typedef logic [PA_DEFAULT_WIDTH-1:0] pa_word_t;

endpackage : parallel_adder_pkg

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//   One-bit full adder cell, the unit of the ripple chain.
//   Ports:
//     a, b : operand bits
//     ci   : carry in
//     s    : sum bit
//     co   : carry out
// ---------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic prop;

   assign prop = a ^ b;
   assign s    = prop ^ ci;
   assign co   = (a & b) | (ci & prop);

endmodule : full_adder

// File: rtl/parallel_adder_4bit.sv
// ---------------------------------------------------------------------------
// parallel_adder_4bit
//   Registered ripple-carry adder: {carry, sumo} = a + b + cin, one cycle
//   of latency, one result per accepted input, no backpressure.
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : asynchronous active-low reset
//     in_valid  : a/b/cin are sampled at the next rising edge when high
//     a, b      : unsigned operands, WIDTH bits
//     cin       : carry in
//     out_valid : one-cycle pulse when sumo/carry hold a fresh result
//     sumo      : sum bits [WIDTH-1:0]
//     carry     : carry out (bit WIDTH of the sum)
//     ovf       : two's-complement overflow (only with PA_OVERFLOW_EN)
//   Configuration:
//     PA_OVERFLOW_EN : when defined, adds the registered ovf output.
// ---------------------------------------------------------------------------
module parallel_adder_4bit
   import parallel_adder_pkg::*;
#(
   parameter int WIDTH = PA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   output logic [WIDTH-1:0] sumo,
   output logic             carry
`ifdef PA_OVERFLOW_EN
   ,
   output logic             ovf
`endif
);

   // c[i] is the carry into stage i; c[WIDTH] is the final carry out.
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] sum_p0;
   logic [WIDTH-1:0] sum_p1;
   logic             carry_p1;
   logic             vld_p1;

   assign c[0] = cin;

   // Stage 0: combinational ripple chain
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      full_adder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (sum_p0[i]),
         .co (c[i+1])
      );
   end

   // Stage 1: output registers; results hold while in_valid is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         sum_p1   <= '0;
         carry_p1 <= 1'b0;
      end else begin
         vld_p1 <= in_valid;
         if (in_valid) begin
            sum_p1   <= sum_p0;
            carry_p1 <= c[WIDTH];
         end
      end
   end

   assign out_valid = vld_p1;
   assign sumo      = sum_p1;
   assign carry     = carry_p1;

`ifdef PA_OVERFLOW_EN
   logic ovf_p0;
   logic ovf_p1;

   // Signed overflow: carry into the MSB differs from carry out of it.
   assign ovf_p0 = c[WIDTH] ^ c[WIDTH-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_p1 <= 1'b0;
      end else if (in_valid) begin
         ovf_p1 <= ovf_p0;
      end
   end

   assign ovf = ovf_p1;
`endif

endmodule : parallel_adder_4bit

// File: tb/tb_parallel_adder_4bit.sv
// ---------------------------------------------------------------------------
// tb_parallel_adder_4bit
//   Self-checking bench for parallel_adder_4bit (WIDTH = 4). Builds with or
//   without PA_OVERFLOW_EN; the ovf checks follow the macro.
// ---------------------------------------------------------------------------
module tb_parallel_adder_4bit;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic       out_valid;
   logic [3:0] sumo;
   logic       carry;
`ifdef PA_OVERFLOW_EN
   logic       ovf;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state: what the outputs should show right now.
   logic [3:0] exp_sum;
   logic       exp_carry;
   logic       exp_vld;
   logic       exp_ovf;

   parallel_adder_4bit #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .sumo      (sumo),
      .carry     (carry)
`ifdef PA_OVERFLOW_EN
      ,
      .ovf       (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, exp_vld});
      chk({tag, ".sumo"},      {28'd0, sumo},      {28'd0, exp_sum});
      chk({tag, ".carry"},     {31'd0, carry},     {31'd0, exp_carry});
`ifdef PA_OVERFLOW_EN
      chk({tag, ".ovf"},       {31'd0, ovf},       {31'd0, exp_ovf});
`endif
   endtask

   // Model: plain integer arithmetic, unsigned for sum/carry, signed
   // range check for overflow.
   task automatic model_accept(input logic [3:0] aa, input logic [3:0] bb, input logic ci);
      int u;
      int sa;
      int sb;
      int ss;
      u  = int'(aa) + int'(bb) + int'(ci);
      sa = (aa >= 4'd8) ? int'(aa) - 16 : int'(aa);
      sb = (bb >= 4'd8) ? int'(bb) - 16 : int'(bb);
      ss = sa + sb + int'(ci);
      exp_sum   = 4'(u % 16);
      exp_carry = (u >= 16);
      exp_ovf   = (ss > 7) || (ss < -8);
      exp_vld   = 1'b1;
   endtask

   // One clock step: drive, clock, check 1 time unit after the edge.
   task automatic step(input logic v, input logic [3:0] aa, input logic [3:0] bb,
                       input logic ci, input string tag);
      in_valid = v;
      a        = aa;
      b        = bb;
      cin      = ci;
      @(posedge clk);
      #1;
      if (v) model_accept(aa, bb, ci);
      else   exp_vld = 1'b0;
      check_all(tag);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      exp_sum   = '0;
      exp_carry = 1'b0;
      exp_vld   = 1'b0;
      exp_ovf   = 1'b0;

      #1;
      check_all("reset_initial");
      repeat (2) @(posedge clk);
      #1;
      check_all("reset_held");
      rst_n = 1'b1;

      step(1'b1, 4'hF, 4'h1, 1'b0, "f_plus_1");
      step(1'b1, 4'h5, 4'h3, 1'b1, "5_plus_3_c");
      step(1'b1, 4'hF, 4'hF, 1'b1, "max");
      step(1'b1, 4'h0, 4'h0, 1'b0, "zero");
      step(1'b1, 4'h2, 4'h4, 1'b0, "2_plus_4");
      step(1'b0, 4'h9, 4'h9, 1'b1, "hold1");
      step(1'b0, 4'h7, 4'hA, 1'b0, "hold2");
      step(1'b1, 4'h7, 4'h0, 1'b1, "pos_ovf");
      step(1'b1, 4'h8, 4'h8, 1'b0, "neg_ovf");

      for (int i = 0; i < 24; i++) begin
         step(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
      end

      // Random gaps between accepted inputs exercise hold behaviour.
      for (int i = 0; i < 12; i++) begin
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              $sformatf("gap%0d", i));
      end

      // Asynchronous reset mid-cycle with a valid input pending.
      step(1'b1, 4'hC, 4'h6, 1'b1, "pre_reset");
      in_valid = 1'b1;
      a        = 4'hA;
      b        = 4'h9;
      cin      = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      exp_sum   = '0;
      exp_carry = 1'b0;
      exp_vld   = 1'b0;
      exp_ovf   = 1'b0;
      check_all("reset_async");
      @(posedge clk);
      #1;
      check_all("reset_during_edge");
      rst_n = 1'b1;
      step(1'b0, 4'hA, 4'h9, 1'b1, "no_stale");
      step(1'b0, 4'h3, 4'h3, 1'b0, "no_stale2");
      step(1'b1, 4'h3, 4'hE, 1'b0, "post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Safety bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule : tb_parallel_adder_4bit
